// File: rtl/spi_shift_port.sv
// SPI slave shift port: oversampled sck/sdi/cs_n, MSB-first shift with daisy-chain sdo, frame capture on release.
// Optional open-drain ready output ready_n_ts_out is enabled by defining SPI_SHIFT_PORT_READY_TS_EN.
module spi_shift_port #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 3,
  parameter int SAMPLE_EDGE = 0
) (
  input  logic                       clk_in,
  input  logic                       reset_in,
  input  logic                       sck_in,
  input  logic                       sdi_in,
  input  logic                       cs_n_in,
  output logic                       sdo_out,
  input  logic                       load_in,
  input  logic [WIDTH-1:0]           load_data_in,
  output logic [WIDTH-1:0]           data_out,
  output logic                       frame_valid_out,
  output logic                       short_frame_out,
  output logic [$clog2(WIDTH+1)-1:0] bit_count_out
`ifdef SPI_SHIFT_PORT_READY_TS_EN
  ,
  output logic                       ready_n_ts_out
`endif
);
  localparam int            CW   = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [SYNC_STAGES-1:0] sck_sync_p0;
  logic [SYNC_STAGES-2:0] sdi_sync_p0;
  logic [SYNC_STAGES-2:0] cs_sync_p0;
  logic                   cs_prev_p1;
  logic [WIDTH-1:0]       shreg_p1;
  logic [CW-1:0]          bit_count_p1;

  logic sck_old, sck_new, cs_now, sdi_now;
  logic edge_active, shift_en, frame_start, frame_end;

  always_comb begin
    sck_old     = sck_sync_p0[SYNC_STAGES-1];
    sck_new     = sck_sync_p0[SYNC_STAGES-2];
    cs_now      = cs_sync_p0[SYNC_STAGES-2];
    sdi_now     = sdi_sync_p0[SYNC_STAGES-2];
    edge_active = (SAMPLE_EDGE == 0) ? (!sck_old && sck_new) : (sck_old && !sck_new);
    shift_en    = edge_active && !cs_now;
    frame_start = cs_prev_p1 && !cs_now;
    frame_end   = !cs_prev_p1 && cs_now;
  end

  // Stage p0: synchronisers; sdi/cs_n are one flop shorter so they line up with the "new" sck tap
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sck_sync_p0 <= '0;
      sdi_sync_p0 <= '0;
      cs_sync_p0  <= '1;
    end else begin
      sck_sync_p0    <= {sck_sync_p0[SYNC_STAGES-2:0], sck_in};
      sdi_sync_p0[0] <= sdi_in;
      cs_sync_p0[0]  <= cs_n_in;
      for (int i = 1; i < SYNC_STAGES-1; i++) begin
        sdi_sync_p0[i] <= sdi_sync_p0[i-1];
        cs_sync_p0[i]  <= cs_sync_p0[i-1];
      end
    end
  end

  // Stage p1: shift register, bit counter and frame capture
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cs_prev_p1      <= 1'b1;
      shreg_p1        <= '0;
      bit_count_p1    <= '0;
      data_out        <= '0;
      frame_valid_out <= 1'b0;
      short_frame_out <= 1'b0;
    end else begin
      cs_prev_p1      <= cs_now;
      frame_valid_out <= 1'b0;
      short_frame_out <= 1'b0;

      if (shift_en) begin
        shreg_p1 <= {shreg_p1[WIDTH-2:0], sdi_now};
      end else if (cs_now && load_in) begin
        shreg_p1 <= load_data_in;
      end

      // Capture reads the pre-load shreg, so a load in the release cycle does not corrupt data_out
      if (frame_end) begin
        bit_count_p1 <= '0;
        if (bit_count_p1 == FULL) begin
          data_out        <= shreg_p1;
          frame_valid_out <= 1'b1;
        end else if (bit_count_p1 != '0) begin
          short_frame_out <= 1'b1;
        end
      end else if (frame_start) begin
        bit_count_p1 <= shift_en ? CW'(1) : '0;
      end else if (shift_en && (bit_count_p1 != FULL)) begin
        bit_count_p1 <= bit_count_p1 + CW'(1);
      end
    end
  end

  assign sdo_out       = shreg_p1[WIDTH-1];
  assign bit_count_out = bit_count_p1;

`ifdef SPI_SHIFT_PORT_READY_TS_EN
  assign ready_n_ts_out = data_out[WIDTH-1] ? 1'b0 : 1'bz;
`endif

endmodule

// File: tb/tb_spi_shift_port.sv
// Bench for spi_shift_port: two instances (32-bit rising-edge, 16-bit falling-edge) against a frame-level model.
`timescale 1ns/1ps
module tb_spi_shift_port;
  localparam int W0 = 32;
  localparam int W1 = 16;

  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  always #5 clk_in = ~clk_in;

  logic [1:0] sck_v = 2'b10;
  logic [1:0] sdi_v = 2'b00;
  logic [1:0] cs_v  = 2'b11;
  logic [1:0] ld_v  = 2'b00;
  logic [W0-1:0] ldd0 = '0;
  logic [W1-1:0] ldd1 = '0;

  logic [1:0] sdo_v, fv_v, sf_v;
  logic [W0-1:0] d0;
  logic [W1-1:0] d1;
  logic [5:0] bc0;
  logic [4:0] bc1;
`ifdef SPI_SHIFT_PORT_READY_TS_EN
  wire rdy0, rdy1;
`endif

  spi_shift_port dut0 (
    .clk_in(clk_in), .reset_in(reset_in), .sck_in(sck_v[0]), .sdi_in(sdi_v[0]), .cs_n_in(cs_v[0]),
    .sdo_out(sdo_v[0]), .load_in(ld_v[0]), .load_data_in(ldd0), .data_out(d0),
    .frame_valid_out(fv_v[0]), .short_frame_out(sf_v[0]), .bit_count_out(bc0)
`ifdef SPI_SHIFT_PORT_READY_TS_EN
    , .ready_n_ts_out(rdy0)
`endif
  );

  spi_shift_port #(.WIDTH(W1), .SYNC_STAGES(4), .SAMPLE_EDGE(1)) dut1 (
    .clk_in(clk_in), .reset_in(reset_in), .sck_in(sck_v[1]), .sdi_in(sdi_v[1]), .cs_n_in(cs_v[1]),
    .sdo_out(sdo_v[1]), .load_in(ld_v[1]), .load_data_in(ldd1), .data_out(d1),
    .frame_valid_out(fv_v[1]), .short_frame_out(sf_v[1]), .bit_count_out(bc1)
`ifdef SPI_SHIFT_PORT_READY_TS_EN
    , .ready_n_ts_out(rdy1)
`endif
  );

  typedef struct packed {
    logic [1:0]  kind;   // {frame_valid, short_frame}
    logic [63:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [63:0] m_sh[2];
  logic [63:0] m_dat[2];
  int wd[2];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] dout(input int sel);
    return (sel == 0) ? 64'(d0) : 64'(d1);
  endfunction

  function automatic logic [63:0] bcnt(input int sel);
    return (sel == 0) ? 64'(bc0) : 64'(bc1);
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  // Monitors: every pulse must match the next expected frame outcome
  exp_t e0, e1;
  always @(negedge clk_in) begin
    if (fv_v[0] || sf_v[0]) begin
      if (q0.size() == 0) chk("dut0_unexpected_pulse", 64'({fv_v[0], sf_v[0]}), 64'd0);
      else begin
        e0 = q0.pop_front();
        chk("dut0_pulse_kind", 64'({fv_v[0], sf_v[0]}), 64'(e0.kind));
        chk("dut0_data_out", 64'(d0), e0.data);
      end
    end
  end
  always @(negedge clk_in) begin
    if (fv_v[1] || sf_v[1]) begin
      if (q1.size() == 0) chk("dut1_unexpected_pulse", 64'({fv_v[1], sf_v[1]}), 64'd0);
      else begin
        e1 = q1.pop_front();
        chk("dut1_pulse_kind", 64'({fv_v[1], sf_v[1]}), 64'(e1.kind));
        chk("dut1_data_out", 64'(d1), e1.data);
      end
    end
  end

  task automatic pulse_load(input int sel, input logic [63:0] data);
    if (sel == 0) ldd0 = data[W0-1:0];
    else ldd1 = data[W1-1:0];
    ld_v[sel] = 1'b1;
    wclk(1);
    ld_v[sel] = 1'b0;
  endtask

  task automatic preload(input int sel, input logic [63:0] data);
    pulse_load(sel, data);
    m_sh[sel] = data & wmask(wd[sel]);
    wclk(2);
    chk($sformatf("dut%0d_preload_sdo", sel), 64'(sdo_v[sel]), 64'(m_sh[sel][wd[sel]-1]));
  endtask

  task automatic send_bit(input int sel, input logic b, output logic s);
    logic idle;
    idle = (sel == 1);
    sdi_v[sel] = b;
    wclk(3);
    s = sdo_v[sel];
    sck_v[sel] = ~idle;
    wclk(6);
    sck_v[sel] = idle;
    wclk(6);
  endtask

  // One frame of n bits (MSB-first from bits[n-1]); load_at >= 0 fires a load at that bit index
  task automatic frame(input int sel, input logic [63:0] bits, input int n, input int load_at);
    logic [127:0] stream;
    logic [63:0]  sdo_exp, sdo_act, bmask;
    logic         s;
    exp_t         e;
    int           w;
    w = wd[sel];
    bmask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    // Whatever sits in the register leaves first, followed by the new bits
    stream  = ({64'd0, m_sh[sel]} << n) | {64'd0, bits & bmask};
    sdo_exp = 64'(stream >> w);
    m_sh[sel] = 64'(stream) & wmask(w);
    if (n >= w) begin
      m_dat[sel] = m_sh[sel];
      e.kind = 2'b10; e.data = m_dat[sel];
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end else if (n > 0) begin
      e.kind = 2'b01; e.data = m_dat[sel];
      if (sel == 0) q0.push_back(e); else q1.push_back(e);
    end

    cs_v[sel] = 1'b0;
    wclk(8);
    sdo_act = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if ((n - 1 - i) == load_at) pulse_load(sel, 64'd1);
      send_bit(sel, bits[i], s);
      sdo_act = {sdo_act[62:0], s};
    end
    chk($sformatf("dut%0d_sdo_stream", sel), sdo_act, sdo_exp);
    chk($sformatf("dut%0d_bit_count_end", sel), bcnt(sel), 64'((n < w) ? n : w));
    cs_v[sel] = 1'b1;
    wclk(10);
    chk($sformatf("dut%0d_bit_count_cleared", sel), bcnt(sel), 64'd0);
    chk($sformatf("dut%0d_pulse_delivered", sel), 64'(qsize(sel)), 64'd0);
  endtask

  initial begin
    logic s;
    int sel, n;
    wd[0] = W0; wd[1] = W1;
    m_sh[0] = '0; m_sh[1] = '0; m_dat[0] = '0; m_dat[1] = '0;

    reset_in = 1'b1;
    wclk(4);
    reset_in = 1'b0;
    wclk(2);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d_reset_data", k), dout(k), 64'd0);
      chk($sformatf("dut%0d_reset_count", k), bcnt(k), 64'd0);
      chk($sformatf("dut%0d_reset_sdo", k), 64'(sdo_v[k]), 64'd0);
      chk($sformatf("dut%0d_reset_pulses", k), 64'({fv_v[k], sf_v[k]}), 64'd0);
    end

    frame(0, 64'hA5A5F00F, 32, -1);
    preload(0, 64'hDEADBEEF);
    frame(0, 64'd0, 32, 5);
    frame(0, 64'h12345678_9ABCDEF0, 64, -1);
    frame(0, 64'hA7, 8, -1);

    // Reset in the middle of a frame discards it
    cs_v[0] = 1'b0;
    wclk(8);
    for (int i = 0; i < 17; i++) send_bit(0, 1'($urandom_range(0, 1)), s);
    chk("dut0_midframe_count", 64'(bc0), 64'd17);
    reset_in = 1'b1;
    wclk(2);
    reset_in = 1'b0;
    m_sh[0] = '0; m_sh[1] = '0; m_dat[0] = '0; m_dat[1] = '0;
    wclk(1);
    chk("dut0_after_reset_data", 64'(d0), 64'd0);
    chk("dut0_after_reset_count", 64'(bc0), 64'd0);
    chk("dut0_after_reset_sdo", 64'(sdo_v[0]), 64'd0);
    cs_v[0] = 1'b1;
    wclk(10);
    chk("dut0_no_pulse_after_reset", 64'(q0.size()), 64'd0);
    frame(0, 64'hFFFFFFFF, 32, -1);

    frame(1, 64'hBEEF, 16, -1);
`ifdef SPI_SHIFT_PORT_READY_TS_EN
    chk("dut1_ready_low", 64'(rdy1 === 1'b0), 64'd1);
`endif
    frame(1, 64'h0001, 16, -1);
`ifdef SPI_SHIFT_PORT_READY_TS_EN
    chk("dut1_ready_z", 64'(rdy1 === 1'bz), 64'd1);
`endif

    for (int it = 0; it < 16; it++) begin
      sel = $urandom_range(0, 1);
      n = $urandom_range(0, 40);
      if ($urandom_range(0, 2) == 0) preload(sel, {$urandom, $urandom});
      frame(sel, {$urandom, $urandom}, n, -1);
    end

    wclk(10);
    chk("dut0_queue_empty", 64'(q0.size()), 64'd0);
    chk("dut1_queue_empty", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
